// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, segment codes and elaboration helpers for the display controller
package display_pkg;

    typedef enum logic [1:0] {IDLE, ADD3, SHIFT, DONE} dd_state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Largest value representable in n decimal digits, wide enough for n up to 10
    function automatic logic [35:0] pow10_minus1(int n);
        logic [35:0] p;
        p = 36'd1;
        for (int k = 0; k < n; k++) begin
            p = p * 36'd10;
        end
        return p - 36'd1;
    endfunction

endpackage

// File: rtl/seven_seg.sv
// rtl/seven_seg.sv - BCD nibble to active-low 7-segment pattern
module seven_seg (
    input  logic [3:0] bcd,
    output logic [6:0] segments
);

    // Decode one BCD digit; non-decimal codes show nothing
    always_comb begin
        segments = 7'h7F;
        case (bcd)
            4'd0: segments = 7'h40;
            4'd1: segments = 7'h79;
            4'd2: segments = 7'h24;
            4'd3: segments = 7'h30;
            4'd4: segments = 7'h19;
            4'd5: segments = 7'h12;
            4'd6: segments = 7'h02;
            4'd7: segments = 7'h78;
            4'd8: segments = 7'h00;
            4'd9: segments = 7'h10;
            default: segments = 7'h7F;
        endcase
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// rtl/bcd_display_ctrl.sv - sequential double-dabble binary to 7-segment display controller
module bcd_display_ctrl
    import display_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int DIGITS   = 4,
    parameter int SIGNED   = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  out_valid,
    output logic                  overflow,
    output logic [DIGITS*7-1:0]   segments
);

    localparam int ND = DIGITS - SIGNED;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [35:0] LIMIT = pow10_minus1(ND);
    localparam logic [35:0] MAXV  = (36'd1 << WIDTH) - 36'd1;
    // When every WIDTH-bit magnitude fits, overflow can never be raised
    localparam bit OVF_POSSIBLE = (LIMIT < MAXV);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("bcd_display_ctrl: WIDTH must be 1..32");
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("bcd_display_ctrl: DIGITS must be 1..10");
    end
    if (SIGNED != 0 && (SIGNED != 1 || DIGITS < 2)) begin : g_bad_signed
        $error("bcd_display_ctrl: SIGNED=1 needs DIGITS>=2");
    end

    dd_state_t               state;
    logic [CW-1:0]           count;
    logic [4*DIGITS-1:0]     bcd_r;
    logic [4*DIGITS-1:0]     bcd_add3;
    logic [WIDTH-1:0]        mag_r;
    logic                    ovf_r;
    logic                    neg_in;
    logic [WIDTH-1:0]        mag_in;
    logic                    ovf_in;
    logic [DIGITS*7-1:0]     seg_next;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    assign neg_in = (SIGNED != 0) && value[WIDTH-1];
    assign mag_in = neg_in ? -value : value;
    assign ovf_in = OVF_POSSIBLE && (36'(mag_in) > LIMIT);

    // Double-dabble correction: any nibble above 4 is bumped by 3 before the shift
    always_comb begin
        bcd_add3 = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] > 4'd4) begin
                bcd_add3[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i < ND) begin : g_num
            logic [6:0] raw;
            logic       lz;

            seven_seg u_seg (
                .bcd      (bcd_r[4*i +: 4]),
                .segments (raw)
            );

            if (BLANK_LZ != 0 && i > 0) begin : g_lz
                assign lz = (bcd_r[4*ND-1 : 4*i] == '0);
            end else begin : g_nolz
                assign lz = 1'b0;
            end

            assign seg_next[7*i +: 7] = ovf_r ? SEG_DASH : (lz ? SEG_BLANK : raw);
        end else begin : g_sign
            logic neg_r;

            // Remember the sign of the accepted value for the reserved top digit
            always_ff @(posedge clk) begin
                if (reset) begin
                    neg_r <= 1'b0;
                end else if (in_valid && state == IDLE) begin
                    neg_r <= value[WIDTH-1];
                end
            end

            assign seg_next[7*i +: 7] = (ovf_r || neg_r) ? SEG_DASH : SEG_BLANK;
        end
    end

    // Conversion FSM; outputs only change in DONE so no intermediate value is ever shown
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            bcd_r     <= '0;
            mag_r     <= '0;
            ovf_r     <= 1'b0;
            segments  <= {DIGITS{SEG_BLANK}};
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_r <= mag_in;
                        ovf_r <= ovf_in;
                        bcd_r <= '0;
                        state <= ADD3;
                    end
                end
                ADD3: begin
                    bcd_r <= bcd_add3;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd_r, mag_r} <= {bcd_r, mag_r} << 1;
                    count          <= count + CW'(1);
                    state          <= (count == LAST) ? DONE : ADD3;
                end
                DONE: begin
                    count     <= '0;
                    segments  <= seg_next;
                    overflow  <= ovf_r;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb/tb_bcd_display_ctrl.sv - self-checking bench for bcd_display_ctrl against a decimal reference model
module tb_bcd_display_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b, reset_c;
    logic [10:0] value_a, value_c;
    logic [15:0] value_b;
    logic        in_valid_a, in_valid_b, in_valid_c;
    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        busy_a, busy_b, busy_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic        overflow_a, overflow_b, overflow_c;
    logic [27:0] segments_a, segments_b, segments_c;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;
    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bcd_display_ctrl #(.WIDTH(11), .DIGITS(4), .SIGNED(0), .BLANK_LZ(1)) dut_a (
        .clk(clk), .reset(reset_a), .value(value_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .busy(busy_a), .out_valid(out_valid_a),
        .overflow(overflow_a), .segments(segments_a));

    bcd_display_ctrl #(.WIDTH(16), .DIGITS(4), .SIGNED(0), .BLANK_LZ(1)) dut_b (
        .clk(clk), .reset(reset_b), .value(value_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .busy(busy_b), .out_valid(out_valid_b),
        .overflow(overflow_b), .segments(segments_b));

    bcd_display_ctrl #(.WIDTH(11), .DIGITS(4), .SIGNED(1), .BLANK_LZ(1)) dut_c (
        .clk(clk), .reset(reset_c), .value(value_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .busy(busy_c), .out_valid(out_valid_c),
        .overflow(overflow_c), .segments(segments_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint p10(input int n);
        longint p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // Decimal reference: what a 4-digit display with leading-zero blanking should show
    function automatic void model(input int w, input bit sgn, input logic [15:0] raw,
                                  output logic [27:0] seg, output bit ovf);
        longint r, mag;
        bit     neg;
        int     nd;
        r   = longint'(raw) & ((64'sd1 <<< w) - 1);
        neg = sgn && (((r >>> (w - 1)) & 1) != 0);
        mag = neg ? ((64'sd1 <<< w) - r) : r;
        nd  = sgn ? 3 : 4;
        ovf = (mag > p10(nd) - 1);
        seg = '0;
        for (int i = 0; i < 4; i++) begin
            if (ovf)                     seg[7*i +: 7] = DASH;
            else if (i >= nd)            seg[7*i +: 7] = neg ? DASH : BLANK;
            else if (i > 0 && mag < p10(i)) seg[7*i +: 7] = BLANK;
            else                         seg[7*i +: 7] = seg_tab[int'((mag / p10(i)) % 10)];
        end
    endfunction

    // Offer one value to all three converters and check result, timing and hold
    task automatic run_one(input logic [15:0] v);
        logic [27:0] ea, eb, ec;
        bit          oa, ob, oc;
        int          fa, fb, fc, pa, pb, pc;
        model(11, 1'b0, v, ea, oa);
        model(16, 1'b0, v, eb, ob);
        model(11, 1'b1, v, ec, oc);
        fa = -1; fb = -1; fc = -1; pa = 0; pb = 0; pc = 0;
        @(negedge clk);
        check("ready", {in_ready_a, in_ready_b, in_ready_c}, 3'b111);
        value_a = v[10:0]; value_b = v; value_c = v[10:0];
        in_valid_a = 1'b1; in_valid_b = 1'b1; in_valid_c = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("busy", {busy_a, busy_b, busy_c}, 3'b111);
            if (out_valid_a) begin
                pa++;
                if (fa < 0) begin
                    fa = cyc;
                    check($sformatf("seg_a v=%0d", v), segments_a, ea);
                    check($sformatf("ovf_a v=%0d", v), overflow_a, oa);
                end
            end
            if (out_valid_b) begin
                pb++;
                if (fb < 0) begin
                    fb = cyc;
                    check($sformatf("seg_b v=%0d", v), segments_b, eb);
                    check($sformatf("ovf_b v=%0d", v), overflow_b, ob);
                end
            end
            if (out_valid_c) begin
                pc++;
                if (fc < 0) begin
                    fc = cyc;
                    check($sformatf("seg_c v=%0d", v), segments_c, ec);
                    check($sformatf("ovf_c v=%0d", v), overflow_c, oc);
                end
            end
        end
        check("lat_a", fa, 24);
        check("lat_b", fb, 34);
        check("lat_c", fc, 24);
        check("pulses", {pa[7:0], pb[7:0], pc[7:0]}, 24'h010101);
        check("hold_a", segments_a, ea);
        check("hold_b", segments_b, eb);
        check("hold_c", segments_c, ec);
    endtask

    logic [10:0] vals [0:96];
    logic [27:0] e6;
    bit          o6;
    int          pulses;

    initial begin
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        value_a = '0; value_b = '0; value_c = '0;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
        repeat (2) @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
        check("rst_ready", {in_ready_a, in_ready_b, in_ready_c}, 3'b111);
        check("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
        check("rst_ovalid", {out_valid_a, out_valid_b, out_valid_c}, 3'b000);
        check("rst_ovf", {overflow_a, overflow_b, overflow_c}, 3'b000);
        check("rst_seg_a", segments_a, {4{BLANK}});
        check("rst_seg_c", segments_c, {4{BLANK}});

        // Directed corners: digits, zero, blanking, overflow edge, signed cases
        run_one(16'd1234);
        run_one(16'd0);
        run_one(16'd70);
        run_one(16'd10000);
        run_one(16'd9999);
        run_one(16'd2003);
        run_one(16'd1024);
        run_one(16'd999);
        run_one(16'd65535);
        for (int k = 0; k < 16; k++) begin
            run_one(16'($urandom_range(0, 65535)));
        end

        // Reset in the middle of a conversion on the 11-bit unsigned unit
        @(negedge clk);
        value_a = 11'd1500; in_valid_a = 1'b1;
        @(posedge clk);
        #1 in_valid_a = 1'b0;
        repeat (10) @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        check("abort_ready", in_ready_a, 1'b1);
        check("abort_seg", segments_a, {4{BLANK}});
        check("abort_ovf", overflow_a, 1'b0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid_a) pulses++;
        end
        check("abort_pulses", pulses, 0);
        run_one(16'd807);

        // Continuous in_valid with a new value every cycle: only handshake values appear
        @(negedge clk);
        vals[0] = 11'($urandom);
        value_a = vals[0]; in_valid_a = 1'b1;
        for (int c = 1; c <= 96; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ovalid c=%0d", c), out_valid_a, (c % 24) == 0);
            if ((c % 24) == 0) begin
                model(11, 1'b0, {5'd0, vals[c-24]}, e6, o6);
                check($sformatf("b2b_seg c=%0d", c), segments_a, e6);
            end
            if (c < 96) begin
                vals[c] = 11'($urandom);
                value_a = vals[c];
            end else begin
                in_valid_a = 1'b0;
            end
        end
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
